// File: rtl/cpu_pmem_bridge_pkg.sv
// Shared types and constants for the CPU-to-64-bit physical memory bridge.
package cpu_pmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    RESP   = 2'd3
  } bridge_state_t;

  localparam int          WORD_W        = 32;
  localparam int          PMEM_DATA_W   = 64;
  localparam int          PMEM_BE_W     = 8;
  localparam int          LANE_SEL_BIT  = 2;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Place a 4-bit word enable onto the upper or lower half of the 8-byte beat.
  function automatic logic [PMEM_BE_W-1:0] lane_be(input logic lane_sel, input logic [3:0] be);
    if (lane_sel) begin
      return {be, 4'h0};
    end else begin
      return {4'h0, be};
    end
  endfunction

endpackage

// File: rtl/cpu_pmem_bridge_align.sv
// mem_lane_align: steers a 32-bit word onto / off the 64-bit physical memory lanes.
module mem_lane_align
  import cpu_pmem_bridge_pkg::*;
(
  input  logic                   lane_sel_i,
  input  logic [WORD_W-1:0]      wdata_i,
  input  logic [3:0]             be_i,
  input  logic [PMEM_DATA_W-1:0] pmem_rdata_i,
  output logic [PMEM_DATA_W-1:0] pmem_wdata_o,
  output logic [PMEM_BE_W-1:0]   pmem_be_o,
  output logic [WORD_W-1:0]      rdata_o
);

  // Write data goes out on both halves; byte enables pick which half memory takes.
  always_comb begin
    pmem_wdata_o = {wdata_i, wdata_i};
    pmem_be_o    = lane_be(lane_sel_i, be_i);
    if (lane_sel_i) begin
      rdata_o = pmem_rdata_i[63:32];
    end else begin
      rdata_o = pmem_rdata_i[31:0];
    end
  end

endmodule

// File: rtl/cpu_pmem_bridge.sv
// cpu_pmem_bridge: registers CPU requests and runs them against a 64-bit physical memory.
// Optional watchdog and sticky bridge_err output: define CPU_PMEM_BRIDGE_TIMEOUT_EN.
module cpu_pmem_bridge
  import cpu_pmem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            mem_address,
  input  logic [WORD_W-1:0]      mem_wdata,
  input  logic [3:0]             mem_byte_enable,
  output logic [WORD_W-1:0]      mem_rdata,
  output logic                   mem_resp,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [31:0]            pmem_address,
  output logic [PMEM_DATA_W-1:0] pmem_wdata,
  output logic [PMEM_BE_W-1:0]   pmem_byte_enable,
  input  logic [PMEM_DATA_W-1:0] pmem_rdata,
  input  logic                   pmem_resp
`ifdef CPU_PMEM_BRIDGE_TIMEOUT_EN
  ,
  output logic                   bridge_err
`endif
);

  bridge_state_t     state_q, state_d;
  logic [31:2]       addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              mem_resp_q, mem_resp_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [WORD_W-1:0] lane_rdata_s;
  logic              tmo_hit_s;
  logic              unused_s;

  assign unused_s = ^{mem_address[1:0]};

  mem_lane_align u_align (
    .lane_sel_i   (addr_q[LANE_SEL_BIT]),
    .wdata_i      (wdata_q),
    .be_i         (be_q),
    .pmem_rdata_i (pmem_rdata),
    .pmem_wdata_o (pmem_wdata),
    .pmem_be_o    (pmem_byte_enable),
    .rdata_o      (lane_rdata_s)
  );

`ifdef CPU_PMEM_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;

  // A pmem_resp landing on the deadline cycle still completes normally.
  assign tmo_hit_s = ((state_q == RD_REQ) || (state_q == WR_REQ)) &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) && !pmem_resp;

  // Watchdog count and sticky error next-state.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        tmo_cnt_d = {TMO_W{1'b0}};
        if (mem_read && mem_write) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      RD_REQ, WR_REQ: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (tmo_hit_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      default: begin
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
      end
    endcase
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= {TMO_W{1'b0}};
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bridge_err = err_q;
`else
  logic unused_tmo_s;

  assign tmo_hit_s    = 1'b0;
  assign unused_tmo_s = (TIMEOUT_CYCLES > 0);
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= 30'h0;
      wdata_q      <= 32'h0;
      be_q         <= 4'h0;
      rdata_q      <= 32'h0;
      mem_resp_q   <= 1'b0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rdata_q      <= rdata_d;
      mem_resp_q   <= mem_resp_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
    end
  end

  // Next-state: a write wins over a simultaneous read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          state_d = WR_REQ;
        end else if (mem_read) begin
          state_d = RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ, WR_REQ: begin
        if (pmem_resp || tmo_hit_s) begin
          state_d = RESP;
        end else begin
          state_d = state_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, response data and registered strobes.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          addr_d  = mem_address[31:2];
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
        end else if (mem_read) begin
          addr_d = mem_address[31:2];
        end else begin
          addr_d = addr_q;
        end
      end
      RD_REQ: begin
        if (pmem_resp) begin
          rdata_d = lane_rdata_s;
        end else if (tmo_hit_s) begin
          rdata_d = TIMEOUT_RDATA;
        end else begin
          rdata_d = rdata_q;
        end
      end
      WR_REQ: begin
        if (tmo_hit_s) begin
          rdata_d = TIMEOUT_RDATA;
        end else begin
          rdata_d = rdata_q;
        end
      end
      default: rdata_d = rdata_q;
    endcase
    pmem_read_d  = (state_d == RD_REQ);
    pmem_write_d = (state_d == WR_REQ);
    mem_resp_d   = (state_d == RESP);
  end

  assign mem_rdata    = rdata_q;
  assign mem_resp     = mem_resp_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = {addr_q[31:3], 3'b000};

endmodule

// File: tb/tb_cpu_pmem_bridge.sv
// Self-checking bench for cpu_pmem_bridge: directed cases plus random traffic against a memory model.
module tb_cpu_pmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata, pmem_rdata;
  logic [7:0]  pmem_byte_enable;
`ifdef CPU_PMEM_BRIDGE_TIMEOUT_EN
  logic        bridge_err;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rd = 32'h0;

  // Physical memory seen by the bridge (8-byte words) and the CPU's own view (4-byte words).
  logic [63:0] pm [int unsigned];
  logic [31:0] cm [int unsigned];

  always #5 clk = ~clk;

  cpu_pmem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_byte_enable  (mem_byte_enable),
    .mem_rdata        (mem_rdata),
    .mem_resp         (mem_resp),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
`ifdef CPU_PMEM_BRIDGE_TIMEOUT_EN
    ,
    .bridge_err       (bridge_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init32(input logic [31:0] a);
    return (({2'b00, a[31:2]}) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [63:0] pm_get(input int unsigned idx);
    if (pm.exists(idx)) return pm[idx];
    return {init32((idx << 3) | 32'd4), init32(idx << 3)};
  endfunction

  function automatic logic [31:0] cm_get(input int unsigned widx);
    if (cm.exists(widx)) return cm[widx];
    return init32(widx << 2);
  endfunction

  task automatic pm_apply(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
    logic [63:0] w;
    w = pm_get(a >> 3);
    for (int j = 0; j < 8; j++) if (be[j]) w[j*8 +: 8] = d[j*8 +: 8];
    pm[a >> 3] = w;
  endtask

  task automatic cm_apply(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = cm_get(a >> 2);
    for (int j = 0; j < 4; j++) if (be[j]) w[j*8 +: 8] = d[j*8 +: 8];
    cm[a >> 2] = w;
  endtask

  // One CPU transaction; pmem_resp is given during the k-th strobe cycle.
  task automatic txn(input bit wr, input bit both, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input int k);
    logic [31:0] exp_addr, obs_addr, exp_rd;
    logic [7:0]  exp_be, obs_be;
    logic [63:0] obs_wd;
    exp_addr = addr & 32'hFFFF_FFF8;
    exp_be   = 8'({4'h0, be}) << (addr[2] ? 4 : 0);
    mem_write = wr; mem_read = !wr || both;
    mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
    @(posedge clk); #1;
    for (int c = 1; c <= k; c++) begin
      chk("pmem_read", pmem_read, 64'(!wr));
      chk("pmem_write", pmem_write, 64'(wr));
      chk("early_resp", mem_resp, 64'd0);
      chk("pmem_address", pmem_address, exp_addr);
      if (wr) begin
        chk("pmem_be", pmem_byte_enable, exp_be);
        chk("pmem_wdata", pmem_wdata, {wd, wd});
      end
      obs_addr = pmem_address; obs_be = pmem_byte_enable; obs_wd = pmem_wdata;
      mem_address = $urandom; mem_wdata = $urandom; mem_byte_enable = 4'($urandom);
      pmem_rdata = {$urandom, $urandom};
      if (c == k) begin
        pmem_resp = 1'b1;
        if (wr) pm_apply(obs_addr, obs_wd, obs_be);
        else    pmem_rdata = pm_get(obs_addr >> 3);
      end
      @(posedge clk); #1;
      pmem_resp = 1'b0;
    end
    chk("mem_resp", mem_resp, 64'd1);
    chk("strobe_drop", {pmem_read, pmem_write}, 64'd0);
    if (wr) begin
      cm_apply(addr, wd, be);
      chk("rdata_hold", mem_rdata, last_rd);
    end else begin
      exp_rd = cm_get(addr >> 2);
      chk("mem_rdata", mem_rdata, exp_rd);
      last_rd = exp_rd;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    chk("resp_one_cycle", mem_resp, 64'd0);
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = 32'h0;
    mem_wdata = 32'h0; mem_byte_enable = 4'h0; pmem_resp = 1'b0; pmem_rdata = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_rdata", mem_rdata, 64'd0);
    chk("rst_mem_resp", mem_resp, 64'd0);
    chk("rst_strobes", {pmem_read, pmem_write}, 64'd0);
    chk("rst_pmem_address", pmem_address, 64'd0);
    chk("rst_pmem_wdata", pmem_wdata, 64'd0);
    chk("rst_pmem_be", pmem_byte_enable, 64'd0);
`ifdef CPU_PMEM_BRIDGE_TIMEOUT_EN
    chk("rst_bridge_err", bridge_err, 64'd0);
`endif
    rst = 1'b0;

    pm[32'h60 >> 3] = 64'h1111_2222_3333_4444;
    cm[32'h60 >> 2] = 32'h3333_4444;
    cm[32'h64 >> 2] = 32'h1111_2222;
    txn(1'b0, 1'b0, 32'h0000_0064, 32'h0, 4'h0, 3);
    chk("dir_read_word", mem_rdata, 64'h1111_2222);
    txn(1'b1, 1'b0, 32'h0000_0080, 32'hCAFE_F00D, 4'b0011, 2);
    txn(1'b1, 1'b0, 32'h0000_0084, 32'h1234_5678, 4'b1100, 1);
    txn(1'b0, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 1);
    txn(1'b0, 1'b0, 32'h0000_0087, 32'h0, 4'h0, 2);
    txn(1'b1, 1'b1, 32'h0000_0090, 32'hA5A5_5A5A, 4'b1111, 2);
    txn(1'b0, 1'b0, 32'h0000_0090, 32'h0, 4'h0, 1);

    // Reset while a read is outstanding, then a late pmem_resp.
    mem_read = 1'b1; mem_address = 32'h0000_00A0;
    @(posedge clk); #1;
    chk("mid_rst_strobe_on", pmem_read, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_read = 1'b0; pmem_resp = 1'b1;
    chk("mid_rst_strobe_off", pmem_read, 64'd0);
    chk("mid_rst_no_resp", mem_resp, 64'd0);
    chk("mid_rst_rdata", mem_rdata, 64'd0);
    last_rd = 32'h0;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    chk("late_resp_ignored", mem_resp, 64'd0);
    chk("late_resp_strobes", {pmem_read, pmem_write}, 64'd0);

    // Spurious pmem_resp in IDLE.
    pmem_resp = 1'b1;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    chk("spurious_no_resp", mem_resp, 64'd0);
    chk("spurious_strobes", {pmem_read, pmem_write}, 64'd0);
    @(posedge clk); #1;
    chk("spurious_no_resp2", mem_resp, 64'd0);

    for (int n = 0; n < 40; n++) begin
      txn(1'($urandom_range(0, 1)), 1'b0,
          32'h100 + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3)),
          $urandom, 4'($urandom_range(0, 15)), $urandom_range(1, 4));
    end

`ifdef CPU_PMEM_BRIDGE_TIMEOUT_EN
    mem_read = 1'b1; mem_address = 32'h0000_0200;
    @(posedge clk); #1;
    for (int c = 1; c <= 8; c++) begin
      chk("tmo_strobe", pmem_read, 64'd1);
      chk("tmo_no_resp", mem_resp, 64'd0);
      @(posedge clk); #1;
    end
    chk("tmo_resp", mem_resp, 64'd1);
    chk("tmo_rdata", mem_rdata, 64'hDEAD_BEEF);
    chk("tmo_err", bridge_err, 64'd1);
    chk("tmo_strobe_drop", pmem_read, 64'd0);
    mem_read = 1'b0;
    last_rd = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("tmo_resp_once", mem_resp, 64'd0);
    txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 2);
    chk("tmo_err_sticky", bridge_err, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("tmo_err_cleared", bridge_err, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
